pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Next-PC generator that feeds the `pc_register` write side. Each cycle it combinationally computes `pc_address` from the registered PC (`pc_out`, wired back as `pc_in`) and from the redirect, trap and return requests. It holds requests that arrive during a stall until `enable` returns. It owns a small return-address stack (RAS) for call/return prediction, and a boot state machine that presents the reset vector.

## Interface
Parameters:
- `RESET_VECTOR`, 32'h0000_0000, first fetch address after reset.
- `TRAP_VECTOR`, 32'h8000_0180, exception entry address.
- `RAS_DEPTH`, 4, RAS entries; must be a power of 2, minimum 2.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `enable`  in  1  same signal as `pc_register.enable`; low means stall.
- `pc_in`  in  32  current PC, from `pc_register.pc_out`.
- `redirect_valid`  in  1  taken branch or jump request.
- `redirect_target`  in  32  branch or jump destination.
- `trap_valid`  in  1  exception request; vectors to `TRAP_VECTOR`.
- `ras_push`  in  1  call: push `pc_in + 4`.
- `ras_pop`  in  1  return: use the RAS top as the next PC.
- `pc_address`  out  32  next PC, to `pc_register.pc_address`.
- `fetch_valid`  out  1  `pc_in` is an architecturally valid fetch.
- `redirect_pending`  out  1  a stalled request is buffered.
- `align_err`  out  1  one-cycle pulse: redirect target had bits [1:0] != 0.
- `ras_underflow`  out  1  one-cycle pulse: pop on an empty RAS.

## Operation
FSM states:
- BOOT
  - Entered on reset.
  - `pc_address` = `RESET_VECTOR`; `fetch_valid` = 0.
  - First cycle with `enable`=1: go to RUN.
- RUN
  - `fetch_valid` = 1.
  - `enable`=0: go to STALL. Any request present that cycle is captured into the pending buffer.
- STALL
  - `pc_address` = `pc_in` (hold); `fetch_valid` = 1.
  - New requests overwrite the pending buffer, except that a redirect never overwrites a pending trap.
  - `enable`=1: go to RUN and apply the request.

Next-PC selection, highest priority first, evaluated when `enable`=1:
1. Live `trap_valid`.
2. Pending trap.
3. Live `redirect_valid`.
4. Pending redirect.
5. `ras_pop` with a non-empty RAS.
6. `pc_in + 4`.

Whenever a selection is applied, the pending buffer clears.

Arithmetic and alignment:
- Additions are 32-bit and wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- A misaligned redirect target is forced to `{target[31:2], 2'b00}` and pulses `align_err` in the cycle it is applied.

RAS:
- Circular buffer with a count of 0..`RAS_DEPTH`. Updates only when `enable`=1.
- Push when full: overwrite the oldest entry; count stays at `RAS_DEPTH`.
- Pop when empty: `ras_underflow` = 1; next PC falls back to `pc_in + 4`.
- Push and pop in the same cycle: the pop selects the current top, then the push writes `pc_in + 4` into that slot; count is unchanged.
- Trap or redirect in the same cycle as a pop: the pop is still consumed (count decrements), but its address is not used.

Reset mid-operation: everything returns to BOOT immediately and asynchronously. The pending buffer and RAS count clear; the pulses drop.

## Timing
- Reset values:
  - `pc_address` = `RESET_VECTOR`
  - `fetch_valid` = 0
  - `redirect_pending` = 0
  - `align_err` = 0
  - `ras_underflow` = 0
  - RAS count = 0
- `pc_address` is combinational from `pc_in`, the live requests and the registered state, so there are zero cycles from input to `pc_address`.
- A request applied in cycle N appears on `pc_out` in N+1.
- A request arriving with `enable`=0 in cycle N:
  - `redirect_pending` = 1 from N+1.
  - It is applied in the first cycle M > N with `enable`=1.
  - `redirect_pending` = 0 from M+1.
- `align_err` and `ras_underflow` are combinational pulses in the applying cycle, 1 cycle wide.
- Requests are level-sampled. The requester must deassert them after the cycle in which they are applied or captured; otherwise they are re-applied.

## Structure
- Shared package `mips_pkg`:
  - `PC_STEP` = 4
  - Default `RESET_VECTOR` and `TRAP_VECTOR`
  - `pc_seq_state_t` enum {BOOT, RUN, STALL}
- One sub-module, `pc_ras`:
  - Ports: `clock`, `reset`, `push`, `pop`, `push_data`, `top`, `empty`, `underflow`.
  - Parameterised by `RAS_DEPTH`.
- Top module: FSM, pending buffer and priority mux.

## Test plan
- Reset, then `enable`=1 with `pc_in` looped from `pc_register` -> `pc_address` = 0x0 during BOOT; `pc_out` sequence 0x0, 0x4, 0x8; `fetch_valid` rises in cycle 2.
- `pc_in`=0x100, `ras_push`; later `pc_in`=0x200, `ras_pop` -> `pc_address` = 0x104. A fifth push at depth 4 drops the oldest entry. Pop on empty -> `ras_underflow`=1 and `pc_address` = `pc_in + 4`.
- Redirect to 0x0040_0003 -> `pc_address` = 0x0040_0000 and `align_err` pulses exactly one cycle.
- Stall -> `pc_address` = `pc_in` while `enable`=0; `redirect_valid` to 0x3000 while stalled -> `redirect_pending`=1. Then a trap arrives while still stalled, followed by another redirect -> the trap is kept. On `enable`=1 -> `pc_address` = 0x8000_0180.
- Same cycle: `trap_valid`, `redirect_valid` and `ras_pop` -> `TRAP_VECTOR` wins and the RAS count decrements. `pc_in`=0xFFFF_FFFC with no request -> `pc_address` = 0x0.
- Assert `reset` low mid-stall with a request pending -> all outputs return to their reset values within the same cycle (asynchronously), and the next fetch is `RESET_VECTOR`.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: PC step, default vectors, sequencer state and pending-request payload.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] PC_STEP              = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_TRAP_VECTOR  = 32'h8000_0180;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        STALL
    } pc_seq_state_t;

    typedef struct packed {
        logic            trap;
        logic            redirect;
        logic [XLEN-1:0] target;
    } pend_req_t;

    // Clear the byte offset so a fetch address is always word aligned.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
    import mips_pkg::*;
#(
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            underflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] count;
    logic             pop_ok;

    assign empty     = (count == CNT_W'(0));
    assign pop_ok    = pop & ~empty;
    assign underflow = pop & empty;
    assign top       = mem[ptr];

    // ptr always addresses the most recent entry; a combined push/pop rewrites it in place.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && pop_ok) begin
            ptr   <= ptr;
            count <= count;
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (count != CNT_W'(RAS_DEPTH)) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop_ok) begin
            ptr   <= ptr - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            if (pop_ok) begin
                mem[ptr] <= push_data;
            end else begin
                mem[ptr + PTR_W'(1)] <= push_data;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC generator: boot FSM, stall-time request buffer, and trap/redirect/return priority mux.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic [XLEN-1:0] pc_in,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic            ras_push,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc_address,
    output logic            fetch_valid,
    output logic            redirect_pending,
    output logic            align_err,
    output logic            ras_underflow
);

    pc_seq_state_t   state, state_next;
    pend_req_t       pend, pend_next;
    logic            ras_do_push, ras_do_pop;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;

    pc_ras #(
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (ras_do_push),
        .pop       (ras_do_pop),
        .push_data (pc_in + PC_STEP),
        .top       (ras_top),
        .empty     (ras_empty),
        .underflow (ras_underflow)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
            pend  <= '0;
        end else begin
            state <= state_next;
            pend  <= pend_next;
        end
    end

    assign redirect_pending = pend.trap | pend.redirect;

    always_comb begin
        state_next  = state;
        pend_next   = pend;
        pc_address  = pc_in;
        fetch_valid = 1'b0;
        align_err   = 1'b0;
        ras_do_push = 1'b0;
        ras_do_pop  = 1'b0;

        case (state)
            BOOT: begin
                pc_address = RESET_VECTOR;
                if (enable) begin
                    state_next = RUN;
                end
            end

            RUN, STALL: begin
                fetch_valid = 1'b1;
                if (enable) begin
                    state_next  = RUN;
                    pend_next   = '0;
                    ras_do_push = ras_push;
                    ras_do_pop  = ras_pop;
                    if (trap_valid || pend.trap) begin
                        pc_address = TRAP_VECTOR;
                    end else if (redirect_valid) begin
                        pc_address = align_word(redirect_target);
                        align_err  = |redirect_target[1:0];
                    end else if (pend.redirect) begin
                        pc_address = align_word(pend.target);
                        align_err  = |pend.target[1:0];
                    end else if (ras_pop && !ras_empty) begin
                        pc_address = ras_top;
                    end else begin
                        pc_address = pc_in + PC_STEP;
                    end
                end else begin
                    // Hold the PC; a trap supersedes any buffered redirect and is never displaced by one.
                    state_next = STALL;
                    if (trap_valid) begin
                        pend_next.trap     = 1'b1;
                        pend_next.redirect = 1'b0;
                    end else if (redirect_valid && !pend.trap) begin
                        pend_next.redirect = 1'b1;
                        pend_next.target   = redirect_target;
                    end
                end
            end

            default: begin
                state_next = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with a behavioural pc_register in the loop.
module tb_pc_sequencer;
    import mips_pkg::*;

    localparam logic [31:0] TRAP = 32'h8000_0180;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] pc_in;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic        ras_push;
    logic        ras_pop;
    logic [31:0] pc_address;
    logic        fetch_valid;
    logic        redirect_pending;
    logic        align_err;
    logic        ras_underflow;

    logic        use_loop;
    logic [31:0] pc_drv;
    logic [31:0] pc_reg;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .pc_in            (pc_in),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .trap_valid       (trap_valid),
        .ras_push         (ras_push),
        .ras_pop          (ras_pop),
        .pc_address       (pc_address),
        .fetch_valid      (fetch_valid),
        .redirect_pending (redirect_pending),
        .align_err        (align_err),
        .ras_underflow    (ras_underflow)
    );

    always #5 clock = ~clock;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) pc_reg <= 32'h0;
        else if (enable) pc_reg <= pc_address;
    end

    assign pc_in = use_loop ? pc_reg : pc_drv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_reqs;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        trap_valid      = 1'b0;
        ras_push        = 1'b0;
        ras_pop         = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_pop [4];
        exp_pop = '{32'h54, 32'h44, 32'h34, 32'h24};

        reset = 1'b0; enable = 1'b0; use_loop = 1'b1; pc_drv = 32'h0;
        clear_reqs();
        #1;
        check("rst_pc_address", pc_address, 32'h0);
        check("rst_fetch_valid", 32'(fetch_valid), 32'h0);
        check("rst_pending", 32'(redirect_pending), 32'h0);
        check("rst_align_err", 32'(align_err), 32'h0);
        check("rst_underflow", 32'(ras_underflow), 32'h0);

        // Boot and sequential fetch with the PC looped back
        @(negedge clock);
        reset = 1'b1; enable = 1'b1;
        #1;
        check("boot_pc_address", pc_address, 32'h0);
        check("boot_fetch_valid", 32'(fetch_valid), 32'h0);
        tick(); #1;
        check("seq_pc_out0", pc_reg, 32'h0);
        check("seq_fetch_valid", 32'(fetch_valid), 32'h1);
        check("seq_pc_address", pc_address, 32'h4);
        tick(); #1;
        check("seq_pc_out1", pc_reg, 32'h4);
        check("seq_pc_address1", pc_address, 32'h8);
        tick(); #1;
        check("seq_pc_out2", pc_reg, 32'h8);

        // RAS call/return
        use_loop = 1'b0;
        pc_drv = 32'h100; ras_push = 1'b1; #1;
        check("call_pc_address", pc_address, 32'h104);
        tick();
        ras_push = 1'b0; pc_drv = 32'h200; ras_pop = 1'b1; #1;
        check("ret_pc_address", pc_address, 32'h104);
        check("ret_underflow", 32'(ras_underflow), 32'h0);
        tick();
        pc_drv = 32'h300; #1;
        check("empty_pop_underflow", 32'(ras_underflow), 32'h1);
        check("empty_pop_pc", pc_address, 32'h304);
        tick();
        ras_pop = 1'b0; #1;
        check("underflow_pulse_end", 32'(ras_underflow), 32'h0);

        // Five pushes at depth 4 drop the oldest (0x14)
        ras_push = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pc_drv = 32'(i + 1) * 32'h10;
            tick();
        end
        ras_push = 1'b0; ras_pop = 1'b1; pc_drv = 32'h900;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("full_pop", pc_address, exp_pop[i]);
            tick();
        end
        #1;
        check("full_drain_underflow", 32'(ras_underflow), 32'h1);
        check("full_drain_pc", pc_address, 32'h904);
        tick();

        // Push and pop together replace the top in place
        ras_pop = 1'b0; ras_push = 1'b1; pc_drv = 32'h60;
        tick();
        ras_pop = 1'b1; pc_drv = 32'h70; #1;
        check("pushpop_pc", pc_address, 32'h64);
        tick();
        ras_push = 1'b0; pc_drv = 32'h900; #1;
        check("pushpop_new_top", pc_address, 32'h74);
        tick(); #1;
        check("pushpop_count", 32'(ras_underflow), 32'h1);
        tick();
        ras_pop = 1'b0;

        // Misaligned redirect
        redirect_valid = 1'b1; redirect_target = 32'h0040_0003; #1;
        check("misalign_pc", pc_address, 32'h0040_0000);
        check("misalign_err", 32'(align_err), 32'h1);
        tick();
        clear_reqs(); #1;
        check("misalign_err_end", 32'(align_err), 32'h0);

        // Stall holds the PC and buffers a redirect
        pc_drv = 32'h500; enable = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h3000; #1;
        check("stall_hold_pc", pc_address, 32'h500);
        check("stall_fetch_valid", 32'(fetch_valid), 32'h1);
        tick();
        clear_reqs(); #1;
        check("stall_pending", 32'(redirect_pending), 32'h1);
        enable = 1'b1; #1;
        check("pending_redirect_apply", pc_address, 32'h3000);
        tick(); #1;
        check("pending_cleared", 32'(redirect_pending), 32'h0);

        // Trap captured during a stall survives a later redirect
        enable = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h3000;
        tick();
        clear_reqs(); trap_valid = 1'b1;
        tick();
        clear_reqs(); redirect_valid = 1'b1; redirect_target = 32'h4000; #1;
        check("stall_hold_pc2", pc_address, 32'h500);
        tick();
        clear_reqs(); #1;
        check("trap_pending", 32'(redirect_pending), 32'h1);
        enable = 1'b1; #1;
        check("pending_trap_apply", pc_address, TRAP);
        tick(); #1;
        check("trap_pending_cleared", 32'(redirect_pending), 32'h0);
        check("after_trap_pc", pc_address, 32'h504);

        // Trap beats redirect and pop; the pop is still consumed
        pc_drv = 32'h600; ras_push = 1'b1;
        tick();
        ras_push = 1'b0; trap_valid = 1'b1; redirect_valid = 1'b1;
        redirect_target = 32'h3000; ras_pop = 1'b1; #1;
        check("trap_wins", pc_address, TRAP);
        check("trap_pop_no_underflow", 32'(ras_underflow), 32'h0);
        tick();
        clear_reqs(); ras_pop = 1'b1; pc_drv = 32'h700; #1;
        check("trap_pop_consumed", 32'(ras_underflow), 32'h1);
        check("trap_pop_fallback", pc_address, 32'h704);
        tick();
        clear_reqs(); pc_drv = 32'hFFFF_FFFC; #1;
        check("pc_wrap", pc_address, 32'h0);

        // Asynchronous reset mid-stall with a request pending
        pc_drv = 32'h800; ras_push = 1'b1;
        tick();
        clear_reqs(); enable = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h7000;
        tick();
        clear_reqs(); pc_drv = 32'hFFFF_FFFC; #1;
        check("pre_reset_pending", 32'(redirect_pending), 32'h1);
        #1 reset = 1'b0;
        #1;
        check("async_rst_pc", pc_address, 32'h0);
        check("async_rst_fetch_valid", 32'(fetch_valid), 32'h0);
        check("async_rst_pending", 32'(redirect_pending), 32'h0);
        check("async_rst_align_err", 32'(align_err), 32'h0);
        check("async_rst_underflow", 32'(ras_underflow), 32'h0);
        @(negedge clock);
        reset = 1'b1; use_loop = 1'b1; enable = 1'b1; #1;
        check("reboot_pc_address", pc_address, 32'h0);
        tick(); #1;
        check("reboot_pc_out", pc_reg, 32'h0);
        use_loop = 1'b0; pc_drv = 32'h900; ras_pop = 1'b1; #1;
        check("reboot_ras_empty", 32'(ras_underflow), 32'h1);
        tick();
        clear_reqs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
